// File: rtl/sha_stream_io_pkg.sv
// Shared types and sizing helpers for the SHA-256 stream front-end.
// The HOLD state exists only when SHA_IO_REREAD_EN is defined.
package sha_io_pkg;

    localparam int unsigned SHA_BLOCK_W  = 512;
    localparam int unsigned SHA_DIGEST_W = 256;

    typedef enum logic [2:0] {
        FILL,
        ISSUE,
        WAIT_DIG,
`ifdef SHA_IO_REREAD_EN
        DRAIN,
        HOLD
`else
        DRAIN
`endif
    } sha_io_state_e;

    // Width of a counter that indexes total_w/bus_w chunks.
    function automatic int unsigned cnt_w(input int unsigned bus_w,
                                          input int unsigned total_w = SHA_BLOCK_W);
        int unsigned n;
        n = total_w / bus_w;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sha_stream_io_if.sv
// Bus bundle between the pin wrapper / hash core and sha_stream_io.
// out_rewind is present only when SHA_IO_REREAD_EN is defined.
interface sha_stream_io_if #(
    parameter int unsigned BUS_W    = 8,
    parameter int unsigned BLOCK_W  = 512,
    parameter int unsigned DIGEST_W = 256
) ();
    logic [BUS_W-1:0]    in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [BLOCK_W-1:0]  blk_data;
    logic                blk_valid;
    logic                blk_last;
    logic                blk_ready;
    logic [DIGEST_W-1:0] dig_data;
    logic                dig_valid;
    logic [BUS_W-1:0]    out_data;
    logic                out_valid;
    logic                out_read;
    logic                busy;
    logic                error;
`ifdef SHA_IO_REREAD_EN
    logic                out_rewind;
`endif

    modport slave (
`ifdef SHA_IO_REREAD_EN
        input  out_rewind,
`endif
        input  in_data, in_valid, in_last, blk_ready, dig_data, dig_valid, out_read,
        output in_ready, blk_data, blk_valid, blk_last, out_data, out_valid, busy, error
    );

    modport master (
`ifdef SHA_IO_REREAD_EN
        output out_rewind,
`endif
        output in_data, in_valid, in_last, blk_ready, dig_data, dig_valid, out_read,
        input  in_ready, blk_data, blk_valid, blk_last, out_data, out_valid, busy, error
    );
endinterface

// File: rtl/sha_stream_io_drain.sv
// Digest holding register and chunked read-out, MSB chunk first.
module sha_io_drain
    import sha_io_pkg::*;
#(
    parameter int unsigned BUS_W    = 8,
    parameter int unsigned DIGEST_W = SHA_DIGEST_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                capture_i,
    input  logic [DIGEST_W-1:0] dig_data_i,
    input  logic                rewind_i,
    input  logic                read_i,
    output logic [BUS_W-1:0]    out_data_o,
    output logic                out_valid_o,
    output logic                last_rd_o
);
    localparam int unsigned NOUT = DIGEST_W / BUS_W;
    localparam int unsigned PW   = cnt_w(BUS_W, DIGEST_W);

    logic [DIGEST_W-1:0] dig_q;
    logic [PW-1:0]       ptr_q;
    logic                vld_q;
    logic                ptr_end;

    always_comb begin
        ptr_end     = (ptr_q == PW'(NOUT - 1));
        last_rd_o   = vld_q & read_i & ptr_end & ~rewind_i;
        out_data_o  = dig_q[(NOUT - 1 - int'(ptr_q)) * BUS_W +: BUS_W];
        out_valid_o = vld_q;
    end

    // Rewind outranks a read in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q <= '0;
            ptr_q <= '0;
            vld_q <= 1'b0;
        end else if (capture_i) begin
            dig_q <= dig_data_i;
            ptr_q <= '0;
            vld_q <= 1'b1;
        end else if (rewind_i) begin
            ptr_q <= '0;
            vld_q <= 1'b1;
        end else if (vld_q && read_i) begin
            if (ptr_end) begin
                ptr_q <= '0;
                vld_q <= 1'b0;
            end else begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sha_stream_io.sv
// Stream front-end for the SHA-256 core: block assembly, core handshake,
// digest read-out. Optional digest re-read via SHA_IO_REREAD_EN.
module sha_stream_io
    import sha_io_pkg::*;
#(
    parameter int unsigned BUS_W    = 8,
    parameter int unsigned BLOCK_W  = SHA_BLOCK_W,
    parameter int unsigned DIGEST_W = SHA_DIGEST_W
) (
    input  logic            clk,
    input  logic            rst,
    sha_stream_io_if.slave  bus
);
    localparam int unsigned NBEAT = BLOCK_W / BUS_W;
    localparam int unsigned CW    = cnt_w(BUS_W, BLOCK_W);

    if (!(BUS_W == 8 || BUS_W == 16 || BUS_W == 32)) begin : g_bad_bus_w
        $error("sha_stream_io: BUS_W must be 8, 16 or 32");
    end
    if ((BLOCK_W % BUS_W) != 0 || NBEAT < 2) begin : g_bad_block_w
        $error("sha_stream_io: BLOCK_W must be a multiple of BUS_W (at least 2 beats)");
    end
    if ((DIGEST_W % BUS_W) != 0) begin : g_bad_digest_w
        $error("sha_stream_io: DIGEST_W must be a multiple of BUS_W");
    end

    sha_io_state_e      state_q;
    logic [CW-1:0]      cnt_q;
    logic [BLOCK_W-1:0] blk_q;
    logic [BLOCK_W-1:0] blk_d;
    logic               last_q;
    logic               err_q;
    logic               in_ready_q;
    logic               blk_valid_q;
    logic               busy_q;

    logic beat_end;
    logic beat_err;
    logic accept;
    logic capture;
    logic rewind_go;
    logic last_rd;

    always_comb begin
        beat_end = (cnt_q == CW'(NBEAT - 1));
        beat_err = bus.in_last & ~beat_end;
        accept   = bus.in_valid & in_ready_q;
        blk_d    = {blk_q[BLOCK_W-BUS_W-1:0], bus.in_data};
        capture  = (state_q == WAIT_DIG) & bus.dig_valid;
`ifdef SHA_IO_REREAD_EN
        rewind_go = bus.out_rewind &
                    ((state_q == DRAIN) | ((state_q == HOLD) & ~bus.in_valid));
`else
        rewind_go = 1'b0;
`endif
    end

    // Beat acceptance is handled after the case so it overrides the
    // FILL/HOLD defaults; in_ready_q is high only in those two states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            blk_q       <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            blk_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (bus.in_valid && !in_ready_q) begin
                err_q <= 1'b1;
            end

            case (state_q)
                ISSUE: begin
                    if (bus.blk_ready) begin
                        blk_valid_q <= 1'b0;
                        if (last_q) begin
                            state_q <= WAIT_DIG;
                        end else begin
                            state_q    <= FILL;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end
                end
                WAIT_DIG: begin
                    if (bus.dig_valid) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!rewind_go && last_rd) begin
                        in_ready_q <= 1'b1;
`ifdef SHA_IO_REREAD_EN
                        state_q    <= HOLD;
`else
                        state_q    <= FILL;
                        busy_q     <= 1'b0;
`endif
                    end
                end
`ifdef SHA_IO_REREAD_EN
                HOLD: begin
                    if (rewind_go) begin
                        state_q    <= DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase

            if (accept) begin
                state_q <= FILL;
                busy_q  <= 1'b0;
                if (beat_err) begin
                    err_q <= 1'b1;
                    cnt_q <= '0;
                    blk_q <= '0;
                end else begin
                    blk_q <= blk_d;
                    if (beat_end) begin
                        cnt_q       <= '0;
                        last_q      <= bus.in_last;
                        state_q     <= ISSUE;
                        in_ready_q  <= 1'b0;
                        blk_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    sha_io_drain #(
        .BUS_W    (BUS_W),
        .DIGEST_W (DIGEST_W)
    ) u_drain (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (capture),
        .dig_data_i  (bus.dig_data),
        .rewind_i    (rewind_go),
        .read_i      (bus.out_read),
        .out_data_o  (bus.out_data),
        .out_valid_o (bus.out_valid),
        .last_rd_o   (last_rd)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.blk_data  = blk_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.error     = err_q;
endmodule

// File: tb/tb_sha_stream_io.sv
// Directed bench for sha_stream_io: an 8-bit and a 32-bit instance.
// Re-read checks are compiled in when SHA_IO_REREAD_EN is defined.
module tb_sha_stream_io;

    localparam logic [255:0] DIG =
        256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha_stream_io_if #(.BUS_W(8))  a ();
    sha_stream_io_if #(.BUS_W(32)) b ();

    sha_stream_io #(.BUS_W(8))  u8  (.clk(clk), .rst(rst), .bus(a.slave));
    sha_stream_io #(.BUS_W(32)) u32 (.clk(clk), .rst(rst), .bus(b.slave));

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    typedef struct {
        logic       rd;
        logic       exp_v;
        logic [7:0] exp_d;
    } drain_vec_t;

    drain_vec_t dtab[34];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat8(input logic [7:0] d, input logic last);
        a.in_valid = 1'b1;
        a.in_data  = d;
        a.in_last  = last;
        tick();
        a.in_valid = 1'b0;
        a.in_last  = 1'b0;
    endtask

    task automatic beat32(input logic [31:0] d, input logic last);
        b.in_valid = 1'b1;
        b.in_data  = d;
        b.in_last  = last;
        tick();
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic hs8();
        a.blk_ready = 1'b1;
        tick();
        a.blk_ready = 1'b0;
    endtask

    task automatic hs32();
        b.blk_ready = 1'b1;
        tick();
        b.blk_ready = 1'b0;
    endtask

    function automatic logic [511:0] pat8(input logic [7:0] base);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[511 - 8*i -: 8] = base + 8'(i);
        return r;
    endfunction

    function automatic logic [511:0] pat32(input logic [31:0] base);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = base + 32'(i);
        return r;
    endfunction

    // Sends 63 beats of a 64-beat block, checks nothing issued yet, then the final beat.
    task automatic block8(input logic [7:0] base, input logic last, input int first);
        for (int i = first; i < 63; i++) beat8(base + 8'(i), 1'b0);
        chk("u8 no early issue", 512'(a.blk_valid), 512'(0));
        beat8(base + 8'd63, last);
        chk("u8 blk_valid", 512'(a.blk_valid), 512'(1));
        chk("u8 blk_last", 512'(a.blk_last), 512'(last));
        chk("u8 blk_data", a.blk_data, pat8(base));
    endtask

    logic [7:0] dv;
    int         j;
    logic       exp_hold;

    initial begin
        rst = 1'b1;
        {a.in_data, a.in_valid, a.in_last, a.blk_ready, a.dig_data, a.dig_valid, a.out_read} = '0;
        {b.in_data, b.in_valid, b.in_last, b.blk_ready, b.dig_data, b.dig_valid, b.out_read} = '0;
`ifdef SHA_IO_REREAD_EN
        a.out_rewind = 1'b0;
        b.out_rewind = 1'b0;
        exp_hold = 1'b1;
`else
        exp_hold = 1'b0;
`endif

        // drain table: every chunk read once, with a stall before chunks 7 and 23
        j = 0;
        for (int i = 0; i < 32; i++) begin
            dv = DIG[255 - 8*i -: 8];
            if (i % 16 == 7) begin
                dtab[j] = '{rd: 1'b0, exp_v: 1'b1, exp_d: dv};
                j++;
            end
            dtab[j] = '{rd: 1'b1, exp_v: 1'b1, exp_d: dv};
            j++;
        end

        tick();
        tick();
        chk("rst in_ready", 512'(a.in_ready), 512'(1));
        chk("rst blk_valid", 512'(a.blk_valid), 512'(0));
        chk("rst blk_last", 512'(a.blk_last), 512'(0));
        chk("rst out_valid", 512'(a.out_valid), 512'(0));
        chk("rst busy", 512'(a.busy), 512'(0));
        chk("rst error", 512'(a.error), 512'(0));
        chk("rst out_data", 512'(a.out_data), 512'(0));
        rst = 1'b0;

        // reset in the middle of a block
        for (int i = 0; i < 10; i++) beat8(8'h40 + 8'(i), 1'b0);
        pulse_rst();
        chk("midrst in_ready", 512'(a.in_ready), 512'(1));
        chk("midrst busy", 512'(a.busy), 512'(0));
        chk("midrst error", 512'(a.error), 512'(0));

        // block A (not last), then backpressure with a dropped beat
        block8(8'h80, 1'b0, 0);
        chk("A in_ready", 512'(a.in_ready), 512'(0));
        chk("A busy", 512'(a.busy), 512'(1));
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                a.in_valid = 1'b1;
                a.in_data  = 8'hEE;
            end
            tick();
            a.in_valid = 1'b0;
            chk("bp blk_valid", 512'(a.blk_valid), 512'(1));
            chk("bp blk_data", a.blk_data, pat8(8'h80));
        end
        chk("bp error", 512'(a.error), 512'(1));
        hs8();
        chk("A hs blk_valid", 512'(a.blk_valid), 512'(0));
        chk("A hs in_ready", 512'(a.in_ready), 512'(1));
        chk("A hs busy", 512'(a.busy), 512'(0));

        // block B (final), digest and read-out
        block8(8'h00, 1'b1, 0);
        hs8();
        chk("wait blk_valid", 512'(a.blk_valid), 512'(0));
        chk("wait busy", 512'(a.busy), 512'(1));
        chk("wait out_valid", 512'(a.out_valid), 512'(0));
        tick();
        a.dig_data  = DIG;
        a.dig_valid = 1'b1;
        tick();
        a.dig_valid = 1'b0;
        for (int k = 0; k < 34; k++) begin
            chk("drain out_valid", 512'(a.out_valid), 512'(dtab[k].exp_v));
            chk("drain out_data", 512'(a.out_data), 512'(dtab[k].exp_d));
            a.out_read = dtab[k].rd;
            tick();
            a.out_read = 1'b0;
        end
        chk("post-drain out_valid", 512'(a.out_valid), 512'(0));
        chk("post-drain in_ready", 512'(a.in_ready), 512'(1));
        chk("post-drain busy", 512'(a.busy), 512'(exp_hold));
        a.out_read = 1'b1;
        tick();
        a.out_read = 1'b0;
        chk("idle read ignored", 512'(a.out_valid), 512'(0));

`ifdef SHA_IO_REREAD_EN
        a.out_rewind = 1'b1;
        tick();
        a.out_rewind = 1'b0;
        chk("rewind out_valid", 512'(a.out_valid), 512'(1));
        chk("rewind out_data", 512'(a.out_data), 512'(8'hBA));
        chk("rewind in_ready", 512'(a.in_ready), 512'(0));
        a.out_read = 1'b1;
        tick();
        a.out_read = 1'b0;
        chk("reread chunk1", 512'(a.out_data), 512'(8'h78));
        a.out_rewind = 1'b1;
        tick();
        a.out_rewind = 1'b0;
        chk("rewind in drain", 512'(a.out_data), 512'(8'hBA));
        a.out_read = 1'b1;
        for (int k = 0; k < 32; k++) tick();
        a.out_read = 1'b0;
        chk("hold out_valid", 512'(a.out_valid), 512'(0));
        chk("hold in_ready", 512'(a.in_ready), 512'(1));
        beat8(8'h10, 1'b0);
        chk("hold->fill busy", 512'(a.busy), 512'(0));
        chk("hold->fill in_ready", 512'(a.in_ready), 512'(1));
        block8(8'h10, 1'b0, 1);
        hs8();
`endif

        // early in_last discards the partial block
        pulse_rst();
        for (int i = 0; i < 10; i++) beat8(8'h55, 1'b0);
        beat8(8'h55, 1'b1);
        chk("early error", 512'(a.error), 512'(1));
        chk("early in_ready", 512'(a.in_ready), 512'(1));
        chk("early blk_valid", 512'(a.blk_valid), 512'(0));
        chk("early busy", 512'(a.busy), 512'(0));
        block8(8'hC0, 1'b1, 0);

        // 32-bit instance: two-block message, stray digest strobe in ISSUE
        pulse_rst();
        for (int i = 0; i < 15; i++) beat32(32'hA000_0000 + 32'(i), 1'b0);
        chk("u32 no early issue", 512'(b.blk_valid), 512'(0));
        beat32(32'hA000_000F, 1'b0);
        chk("u32 blk1 valid", 512'(b.blk_valid), 512'(1));
        chk("u32 blk1 last", 512'(b.blk_last), 512'(0));
        chk("u32 blk1 data", b.blk_data, pat32(32'hA000_0000));
        b.dig_data  = DIG;
        b.dig_valid = 1'b1;
        tick();
        b.dig_valid = 1'b0;
        chk("u32 stray dig out_valid", 512'(b.out_valid), 512'(0));
        chk("u32 stray dig blk_valid", 512'(b.blk_valid), 512'(1));
        hs32();
        chk("u32 hs1 blk_valid", 512'(b.blk_valid), 512'(0));
        chk("u32 hs1 in_ready", 512'(b.in_ready), 512'(1));
        for (int i = 0; i < 15; i++) beat32(32'hB000_0000 + 32'(i), 1'b0);
        beat32(32'hB000_000F, 1'b1);
        chk("u32 blk2 valid", 512'(b.blk_valid), 512'(1));
        chk("u32 blk2 last", 512'(b.blk_last), 512'(1));
        chk("u32 blk2 data", b.blk_data, pat32(32'hB000_0000));
        hs32();
        b.dig_valid = 1'b1;
        tick();
        b.dig_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("u32 out_valid", 512'(b.out_valid), 512'(1));
            chk("u32 out_data", 512'(b.out_data), 512'(DIG[255 - 32*i -: 32]));
            b.out_read = 1'b1;
            tick();
            b.out_read = 1'b0;
        end
        chk("u32 end out_valid", 512'(b.out_valid), 512'(0));
        chk("u32 end busy", 512'(b.busy), 512'(exp_hold));
        chk("u32 end error", 512'(b.error), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
